karatsuba_seq_ctrl: RTL and testbench
=====================================

# karatsuba_seq_ctrl

Sequential Karatsuba multiplier for 8-bit unsigned operands: it time-shares one 5x5 partial-product multiplier across three passes (Z2, Z0, A) and combines them into a 16-bit product. It is used wherever the multiplier must cost less area than a fully parallel Karatsuba tree. It uses the same factorisation as the combinational A factor: A = (Xh+Xl)·(Yh+Yl), 10 bits wide. Operands are taken and results returned over valid/ready handshakes.

## Interface

- No parameters; operand width is fixed at 8 bits and split into 4-bit halves.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair X/Y is valid.
- in_ready  output  1  block is able to accept operands.
- X  input  8  multiplicand (unsigned).
- Y  input  8  multiplier (unsigned).
- out_valid  output  1  P holds a finished product.
- out_ready  input  1  consumer accepts P.
- P  output  16  product X·Y.
- busy  output  1  high in every state except IDLE.
- ops  output  8  count of delivered products.
- err  output  1  sticky self-check failure. Present only with KARATSUBA_CHECK_EN.

## Operation

- FSM states: IDLE, MUL_HI, MUL_LO, MUL_MID, COMBINE, DONE.
- IDLE: in_ready=1. On in_valid, latch X and Y into operand registers and go to MUL_HI.
- MUL_HI: multiplier inputs are {0,Xh} and {0,Yh}. Register Z2 (8 bits). Go to MUL_LO.
- MUL_LO: multiplier inputs are {0,Xl} and {0,Yl}. Register Z0 (8 bits). Go to MUL_MID.
- MUL_MID: multiplier inputs are (Xh+Xl) and (Yh+Yl), each 5 bits. Register A (10 bits, max 900). Go to COMBINE.
- COMBINE: compute M = A − Z2 − Z0 (9 bits, max 450, never negative).
  - Register P = (Z2<<8) + (M<<4) + Z0, 16 bits with no overflow.
  - Go to DONE.
- DONE: out_valid=1 and P is stable.
  - On out_ready: increment ops (modulo 256, 255→0) and go to IDLE.
  - Otherwise hold in DONE.
- The multiplier is a single shared 5x5→10 unsigned instance. Its operand mux is selected by state, and its inputs are zero in IDLE, COMBINE and DONE.
- in_valid outside IDLE is ignored. Operand registers change only on acceptance.
- X and Y may change after acceptance without affecting the result.

## Timing

- Acceptance happens at edge 0 when in_valid && in_ready.
- MUL_HI, MUL_LO, MUL_MID and COMBINE occupy edges 1–4. out_valid is high from edge 5.
- Latency from acceptance to out_valid is 5 cycles. Minimum initiation interval is 6 cycles (DONE→IDLE takes one edge).
- in_ready and out_valid are decoded from state only. There is no combinational path from in_valid or out_ready.
- Simultaneous out_valid && out_ready: the product is consumed that edge and in_ready rises next cycle. There is no same-cycle re-acceptance.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - P=0, ops=0, err=0.
  - Z2, Z0 and A are all 0.
- Reset mid-operation, in any state including DONE, aborts the operation at that edge. No partial product is delivered and ops does not increment.
- rst has priority over all handshakes in the same cycle.

## Configuration

- KARATSUBA_CHECK_EN defined:
  - In COMBINE, the datapath also computes the reference X·Y using a behavioural `*`.
  - On mismatch, err is set at the same edge P is registered. err stays set until rst.
- KARATSUBA_CHECK_EN undefined: there is no err port, no reference multiplier, and no extra logic. All other behaviour is identical.

## Test plan

- X=0x00, Y=0x00 → out_valid 5 cycles after acceptance with P=0x0000. After the handshake, ops=1.
- X=0x65, Y=0x05 → Z2=0, Z0=25, A=55, M=30, P=0x01F9.
- X=0xFF, Y=0xFF → Z2=225, Z0=225, A=900, M=450, P=0xFE01. err stays 0 with the macro defined.
- X=0x01, Y=0x05 with out_ready low for 3 cycles in DONE → P=0x0005 holds. A new in_valid during the stall is ignored. in_ready rises only after the handshake.
- Assert rst during MUL_MID → the next cycle shows IDLE, in_ready=1, out_valid=0, ops unchanged. A following X=0x12, Y=0x34 yields P=0x03A8.
- Run 256 back-to-back products against a scoreboard → ops wraps to 0x00. The minimum spacing between acceptances is 6 cycles.

Source files
------------

// File: rtl/karatsuba_seq_ctrl_if.sv
// rtl/karatsuba_seq_ctrl_if.sv - operand/result handshake bundle for karatsuba_seq_ctrl
//
// Signals:
//   in_valid  producer -> block   operand pair X/Y is valid
//   in_ready  block -> producer   block can accept operands
//   X, Y      producer -> block   8-bit unsigned operands
//   out_valid block -> consumer   P holds a finished product
//   out_ready consumer -> block   consumer accepts P
//   P         block -> consumer   16-bit product
// Modports: master = environment side, slave = multiplier side.

interface karatsuba_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  X;
    logic [7:0]  Y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P;

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, P
    );
endinterface

// File: rtl/karatsuba_seq_ctrl.sv
// rtl/karatsuba_seq_ctrl.sv - sequential 8x8 Karatsuba multiplier sharing one 5x5 multiplier
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of karatsuba_seq_ctrl_if (X/Y in, P out, valid/ready both ways)
//   busy  out  high in every state except IDLE
//   ops   out  count of delivered products, modulo 256
//   err   out  sticky self-check failure (only when KARATSUBA_CHECK_EN is defined)
//
// Optional feature: define KARATSUBA_CHECK_EN to add a behavioural reference
// multiply in COMBINE and the sticky err output.

module karatsuba_seq_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    karatsuba_seq_ctrl_if.slave  bus,
    output logic                 busy,
    output logic [7:0]           ops
`ifdef KARATSUBA_CHECK_EN
    ,
    output logic                 err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_HI,
        S_MUL_LO,
        S_MUL_MID,
        S_COMBINE,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic [7:0]  z2_q;
    logic [7:0]  z0_q;
    logic [9:0]  a_q;
    logic [15:0] p_q;
    logic [7:0]  ops_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;

    // Shared multiplier operands: zero outside the three multiply passes.
    logic [4:0]  mul_a;
    logic [4:0]  mul_b;
    logic [9:0]  mul_p;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_MUL_HI: begin
                mul_a = {1'b0, x_q[7:4]};
                mul_b = {1'b0, y_q[7:4]};
            end
            S_MUL_LO: begin
                mul_a = {1'b0, x_q[3:0]};
                mul_b = {1'b0, y_q[3:0]};
            end
            S_MUL_MID: begin
                mul_a = {1'b0, x_q[7:4]} + {1'b0, x_q[3:0]};
                mul_b = {1'b0, y_q[7:4]} + {1'b0, y_q[3:0]};
            end
            default: ;
        endcase
    end

    assign mul_p = {5'b0, mul_a} * {5'b0, mul_b};

    // M = A - Z2 - Z0 is at most 450 and never negative, so bit 9 is always
    // zero and the recombination below cannot overflow 16 bits.
    logic [9:0]  mid;
    logic [15:0] p_d;

    assign mid = a_q - {2'b0, z2_q} - {2'b0, z0_q};
    assign p_d = {z2_q, 8'h00} + ({6'b0, mid} << 4) + {8'h00, z0_q};

`ifdef KARATSUBA_CHECK_EN
    logic [15:0] ref_p;
    logic        err_q;

    assign ref_p = {8'h00, x_q} * {8'h00, y_q};
    assign err   = err_q;
`endif

    // Handshake outputs are registered alongside the state so they always
    // equal the decode of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z2_q        <= '0;
            z0_q        <= '0;
            a_q         <= '0;
            p_q         <= '0;
            ops_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KARATSUBA_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x_q        <= bus.X;
                        y_q        <= bus.Y;
                        state_q    <= S_MUL_HI;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_MUL_HI: begin
                    z2_q    <= mul_p[7:0];
                    state_q <= S_MUL_LO;
                end
                S_MUL_LO: begin
                    z0_q    <= mul_p[7:0];
                    state_q <= S_MUL_MID;
                end
                S_MUL_MID: begin
                    a_q     <= mul_p;
                    state_q <= S_COMBINE;
                end
                S_COMBINE: begin
                    p_q         <= p_d;
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
`ifdef KARATSUBA_CHECK_EN
                    if (p_d != ref_p) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        ops_q       <= ops_q + 8'd1;
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.P         = p_q;
    assign busy          = busy_q;
    assign ops           = ops_q;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// tb/tb_karatsuba_seq_ctrl.sv - self-checking bench for karatsuba_seq_ctrl

module tb_karatsuba_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [7:0] ops;
`ifdef KARATSUBA_CHECK_EN
    logic       err;
`endif

    int total;
    int bad;
    int exp_ops;

    karatsuba_seq_ctrl_if bus ();

    karatsuba_seq_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .ops  (ops)
`ifdef KARATSUBA_CHECK_EN
        ,
        .err  (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand pair for a single cycle and waits for out_valid.
    // Returns the latency in cycles, or -1 if out_valid never appeared.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, output int lat);
        bus.X        = x;
        bus.Y        = y;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.X        = ~x;
        bus.Y        = ~y;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_ops = (exp_ops + 1) % 256;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
    endtask

    task automatic test_reset();
        bus.X = 8'hA5;
        bus.Y = 8'h5A;
        pulse_reset();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (bus.P !== 16'h0000) begin bad++; $display("FAIL reset_p got=%h want=0000", bus.P); end
        total++; if (ops !== 8'h00) begin bad++; $display("FAIL reset_ops got=%h want=00", ops); end
        total++; if (dut.a_q !== 10'd0 || dut.z2_q !== 8'd0 || dut.z0_q !== 8'd0) begin
            bad++; $display("FAIL reset_partials got=%0d/%0d/%0d want=0/0/0", dut.z2_q, dut.z0_q, dut.a_q);
        end
`ifdef KARATSUBA_CHECK_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
`endif
    endtask

    task automatic test_zero();
        int lat;
        run_op(8'h00, 8'h00, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL zero_latency got=%0d want=5", lat); end
        total++; if (bus.P !== 16'h0000) begin bad++; $display("FAIL zero_p got=%h want=0000", bus.P); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_done got=%0b want=1", busy); end
        consume();
        total++; if (ops !== 8'd1) begin bad++; $display("FAIL zero_ops got=%0d want=1", ops); end
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL zero_idle got=%0b/%0b want=1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_mixed();
        int lat;
        run_op(8'h65, 8'h05, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL mixed_latency got=%0d want=5", lat); end
        total++; if (bus.P !== 16'h01F9) begin bad++; $display("FAIL mixed_p got=%h want=01f9", bus.P); end
        total++; if (dut.z2_q !== 8'd0) begin bad++; $display("FAIL mixed_z2 got=%0d want=0", dut.z2_q); end
        total++; if (dut.z0_q !== 8'd25) begin bad++; $display("FAIL mixed_z0 got=%0d want=25", dut.z0_q); end
        total++; if (dut.a_q !== 10'd55) begin bad++; $display("FAIL mixed_a got=%0d want=55", dut.a_q); end
        consume();
    endtask

    task automatic test_max();
        int lat;
        run_op(8'hFF, 8'hFF, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL max_latency got=%0d want=5", lat); end
        total++; if (bus.P !== 16'hFE01) begin bad++; $display("FAIL max_p got=%h want=fe01", bus.P); end
        total++; if (dut.z2_q !== 8'd225 || dut.z0_q !== 8'd225) begin
            bad++; $display("FAIL max_z2z0 got=%0d/%0d want=225/225", dut.z2_q, dut.z0_q);
        end
        total++; if (dut.a_q !== 10'd900) begin bad++; $display("FAIL max_a got=%0d want=900", dut.a_q); end
`ifdef KARATSUBA_CHECK_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL max_err got=%0b want=0", err); end
`endif
        consume();
        total++; if (ops !== exp_ops[7:0]) begin bad++; $display("FAIL max_ops got=%0d want=%0d", ops, exp_ops); end
    endtask

    task automatic test_stall();
        int lat;
        run_op(8'h01, 8'h05, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL stall_latency got=%0d want=5", lat); end
        bus.X        = 8'h77;
        bus.Y        = 8'h99;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1 || bus.P !== 16'h0005) begin
                bad++; $display("FAIL stall_hold cycle=%0d got=%0b/%h want=1/0005", i, bus.out_valid, bus.P);
            end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cycle=%0d got=%0b want=0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        consume();
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release got=%0b/%0b want=1/0", bus.in_ready, bus.out_valid);
        end
        total++; if (ops !== exp_ops[7:0]) begin bad++; $display("FAIL stall_ops got=%0d want=%0d", ops, exp_ops); end
        total++; if (bus.P !== 16'h0005) begin bad++; $display("FAIL stall_p_after got=%h want=0005", bus.P); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        pulse_reset();
        bus.X        = 8'hAA;
        bus.Y        = 8'h55;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (dut.state_q !== dut.S_MUL_MID) begin bad++; $display("FAIL rstmid_state got=%0d want=%0d", dut.state_q, dut.S_MUL_MID); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_idle got=%0b/%0b/%0b want=1/0/0", bus.in_ready, bus.out_valid, busy);
        end
        total++; if (ops !== exp_ops[7:0]) begin bad++; $display("FAIL rstmid_ops got=%0d want=%0d", ops, exp_ops); end
        run_op(8'h12, 8'h34, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL rstmid_latency got=%0d want=5", lat); end
        total++; if (bus.P !== 16'h03A8) begin bad++; $display("FAIL rstmid_p got=%h want=03a8", bus.P); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q[$];
        logic [15:0] exp_p;
        int accepted;
        int delivered;
        int last_acc;
        int cyc;
        pulse_reset();
        accepted      = 0;
        delivered     = 0;
        last_acc      = 0;
        cyc           = 0;
        bus.out_ready = 1'b1;
        while (delivered < 256 && cyc < 4000) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL b2b_unexpected got=%h want=none", bus.P);
                end else begin
                    exp_p = exp_q.pop_front();
                    total++; if (bus.P !== exp_p) begin bad++; $display("FAIL b2b_p idx=%0d got=%h want=%h", delivered, bus.P, exp_p); end
                end
                delivered++;
            end
            if (bus.in_ready && accepted < 256) begin
                if (accepted > 0) begin
                    total++; if (cyc - last_acc !== 6) begin bad++; $display("FAIL b2b_spacing idx=%0d got=%0d want=6", accepted, cyc - last_acc); end
                end
                last_acc     = cyc;
                bus.X        = 8'($urandom_range(0, 255));
                bus.Y        = 8'($urandom_range(0, 255));
                exp_q.push_back(16'(bus.X) * 16'(bus.Y));
                bus.in_valid = 1'b1;
                accepted++;
            end else begin
                bus.in_valid = 1'b0;
                bus.X        = 8'($urandom_range(0, 255));
                bus.Y        = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (delivered !== 256) begin bad++; $display("FAIL b2b_count got=%0d want=256", delivered); end
        total++; if (ops !== 8'h00) begin bad++; $display("FAIL b2b_ops_wrap got=%h want=00", ops); end
`ifdef KARATSUBA_CHECK_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%0b want=0", err); end
`endif
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        exp_ops       = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.X         = 8'h00;
        bus.Y         = 8'h00;
        @(negedge clk);
        test_reset();
        test_zero();
        test_mixed();
        test_max();
        test_stall();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
